// File: rtl/mips_pkg.sv
// Shared types and encodings for the MIPS execute stage.
// Multiplier support is built only when EX_MULT_EN is defined.
package mips_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10,
        AOP_OR    = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10,
        FWD_RF2 = 2'b11
    } fwd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10,
        BR_RSV  = 2'b11
    } branch_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_MFHI,
        ALU_MFLO,
        ALU_MUL,
        ALU_NOP
    } alu_op_e;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_e;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;

    // 11 is an unused encoding and falls back to the register file
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf,
        input logic [XLEN-1:0] mem,
        input logic [XLEN-1:0] wb
    );
        logic [XLEN-1:0] r;
        unique case (sel)
            FWD_MEM: r = mem;
            FWD_WB:  r = wb;
            default: r = rf;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding paths and EX/MEM outputs of the execute stage.
// slave is the stage itself, master is whoever drives ID/EX.
interface ex_stage_if #(
    parameter int DATA_W = 32
);
    logic              ex_alusrc;
    logic              ex_regdst;
    logic              ex_memwrite;
    logic              ex_memread;
    logic              ex_memtoreg;
    logic              ex_regwrite;
    logic [1:0]        ex_aluop;
    logic [1:0]        ex_branch;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_instr;
    logic [DATA_W-1:0] ex_pc;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [DATA_W-1:0] mem_fwd;
    logic [DATA_W-1:0] wb_fwd;
    logic              flush;
    logic              stall_out;
    logic [DATA_W-1:0] mem_alu;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_btarget;
    logic [4:0]        mem_wreg;
    logic              mem_memwrite;
    logic              mem_memread;
    logic              mem_memtoreg;
    logic              mem_regwrite;
    logic              mem_btaken;

    modport slave (
        input  ex_alusrc, ex_regdst, ex_memwrite,
        input  ex_memread, ex_memtoreg, ex_regwrite,
        input  ex_aluop, ex_branch,
        input  ex_rd1, ex_rd2, ex_imm, ex_instr, ex_pc,
        input  fwd_a, fwd_b, mem_fwd, wb_fwd, flush,
        output stall_out,
        output mem_alu, mem_wdata, mem_btarget, mem_wreg,
        output mem_memwrite, mem_memread, mem_memtoreg,
        output mem_regwrite, mem_btaken
    );

    modport master (
        output ex_alusrc, ex_regdst, ex_memwrite,
        output ex_memread, ex_memtoreg, ex_regwrite,
        output ex_aluop, ex_branch,
        output ex_rd1, ex_rd2, ex_imm, ex_instr, ex_pc,
        output fwd_a, fwd_b, mem_fwd, wb_fwd, flush,
        input  stall_out,
        input  mem_alu, mem_wdata, mem_btarget, mem_wreg,
        input  mem_memwrite, mem_memread, mem_memtoreg,
        input  mem_regwrite, mem_btaken
    );
endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add MULT/MULTU unit owning HI/LO.
// Active only with EX_MULT_EN; otherwise a stub with busy tied low.
module ex_mul_iter
    import mips_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_signed,
    input  logic              flush,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
`ifdef EX_MULT_EN
    localparam int CW = $clog2(MUL_STEPS);

    mul_state_e          state;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] acc;
    logic                neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;

    assign a_mag = (is_signed && a[DATA_W-1]) ? -a : a;
    assign b_mag = (is_signed && b[DATA_W-1]) ? -b : b;

    // acc holds {partial sum, remaining multiplier bits}
    assign sum  = {1'b0, acc[2*DATA_W-1:DATA_W]}
                + {1'b0, acc[0] ? mcand : '0};
    assign prod = neg ? -acc : acc;

    // gated by reset so an abort drops stall at once
    assign busy = reset && !flush
               && ((state == MUL_IDLE && start)
                   || state == MUL_BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MUL_IDLE;
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (flush) begin
            state <= MUL_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand <= a_mag;
                        acc   <= {{DATA_W{1'b0}}, b_mag};
                        neg   <= is_signed
                               & (a[DATA_W-1] ^ b[DATA_W-1]);
                        cnt   <= '0;
                        state <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    acc <= {sum, acc[DATA_W-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MUL_STEPS - 1))
                        state <= MUL_DONE;
                end
                MUL_DONE: begin
                    {hi, lo} <= prod;
                    state    <= MUL_IDLE;
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, reset, start, is_signed,
                         flush, a, b};
    assign busy = 1'b0;
    assign hi   = '0;
    assign lo   = '0;
`endif
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU control, forwarding, ALU, branch and EX/MEM register.
// Build with EX_MULT_EN to add MULT/MULTU, HI/LO and MFHI/MFLO.
module ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MUL_STEPS = 32
) (
    input logic       clk,
    input logic       reset,
    ex_stage_if.slave bus
);
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] fwd_b_val;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] btarget;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [4:0]        wreg;
    alu_op_e           alu_op;
    logic              rw_ok;
    logic              taken;
    logic              stall;
    logic              bubble;
    logic              mul_start;
    logic              mul_signed;
    logic              unused_ok;

    assign funct = bus.ex_instr[5:0];
    assign shamt = bus.ex_instr[10:6];
    assign unused_ok = ^{bus.ex_instr[31:21],
                         bus.ex_imm[31:30]};

    assign op_a = fwd_sel(bus.fwd_a, bus.ex_rd1,
                          bus.mem_fwd, bus.wb_fwd);
    assign fwd_b_val = fwd_sel(bus.fwd_b, bus.ex_rd2,
                               bus.mem_fwd, bus.wb_fwd);
    assign op_b = bus.ex_alusrc ? bus.ex_imm : fwd_b_val;

    always_comb begin
        alu_op = ALU_NOP;
        unique case (bus.ex_aluop)
            AOP_ADD: alu_op = ALU_ADD;
            AOP_SUB: alu_op = ALU_SUB;
            AOP_OR:  alu_op = ALU_OR;
            AOP_FUNCT: begin
                unique case (1'b1)
                    (funct == F_ADD): alu_op = ALU_ADD;
                    (funct == F_SUB): alu_op = ALU_SUB;
                    (funct == F_AND): alu_op = ALU_AND;
                    (funct == F_OR):  alu_op = ALU_OR;
                    (funct == F_NOR): alu_op = ALU_NOR;
                    (funct == F_SLT): alu_op = ALU_SLT;
                    (funct == F_SLL): alu_op = ALU_SLL;
                    (funct == F_SRL): alu_op = ALU_SRL;
`ifdef EX_MULT_EN
                    (funct == F_MFHI): alu_op = ALU_MFHI;
                    (funct == F_MFLO): alu_op = ALU_MFLO;
                    (funct == F_MULT),
                    (funct == F_MULTU): alu_op = ALU_MUL;
`else
                    (funct == F_MFHI),
                    (funct == F_MFLO),
                    (funct == F_MULT),
                    (funct == F_MULTU): alu_op = ALU_NOP;
`endif
                    default: alu_op = ALU_NOP;
                endcase
            end
            default: alu_op = ALU_NOP;
        endcase
    end

    // multiplies write HI/LO only, never the register file
    assign rw_ok = (alu_op != ALU_NOP) && (alu_op != ALU_MUL);
    assign mul_start  = (alu_op == ALU_MUL);
    assign mul_signed = (funct == F_MULT);

    always_comb begin
        result = '0;
        unique case (alu_op)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_AND:  result = op_a & op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_NOR:  result = ~(op_a | op_b);
            ALU_SLT:  result = DATA_W'($signed(op_a)
                                     < $signed(op_b));
            ALU_SLL:  result = op_b << shamt;
            ALU_SRL:  result = op_b >> shamt;
            ALU_MFHI: result = hi;
            ALU_MFLO: result = lo;
            default:  result = '0;
        endcase
    end

    assign btarget = bus.ex_pc
                   + {bus.ex_imm[DATA_W-3:0], 2'b00};
    assign taken = (bus.ex_branch == BR_EQ && op_a == op_b)
                || (bus.ex_branch == BR_NE && op_a != op_b);
    assign wreg = bus.ex_regdst ? bus.ex_instr[15:11]
                                : bus.ex_instr[20:16];

    ex_mul_iter #(
        .DATA_W    (DATA_W),
        .MUL_STEPS (MUL_STEPS)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start     (mul_start),
        .is_signed (mul_signed),
        .flush     (bus.flush),
        .a         (op_a),
        .b         (op_b),
        .busy      (stall),
        .hi        (hi),
        .lo        (lo)
    );

    assign bus.stall_out = stall;
    assign bubble = bus.flush | stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mem_alu      <= '0;
            bus.mem_wdata    <= '0;
            bus.mem_btarget  <= '0;
            bus.mem_wreg     <= '0;
            bus.mem_memwrite <= 1'b0;
            bus.mem_memread  <= 1'b0;
            bus.mem_memtoreg <= 1'b0;
            bus.mem_regwrite <= 1'b0;
            bus.mem_btaken   <= 1'b0;
        end else begin
            bus.mem_alu      <= result;
            bus.mem_wdata    <= fwd_b_val;
            bus.mem_btarget  <= btarget;
            bus.mem_wreg     <= wreg;
            bus.mem_memtoreg <= bus.ex_memtoreg;
            bus.mem_memwrite <= bus.ex_memwrite & ~bubble;
            bus.mem_memread  <= bus.ex_memread & ~bubble;
            bus.mem_regwrite <= bus.ex_regwrite & rw_ok
                              & ~bubble;
            bus.mem_btaken   <= taken & ~bubble;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: cycle-level reference model plus directed checks.
// Multiplier scenarios are selected by EX_MULT_EN, matching the DUT build.
module tb_ex_stage;

`ifdef EX_MULT_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_prod;
    int          m_cnt;
    logic [31:0] e_alu, e_wdata, e_bt;
    logic [4:0]  e_wreg;
    logic        e_mw, e_mr, e_mt, e_rw, e_bk;

    function automatic logic [31:0] fwd(input logic [1:0] s,
                                        input logic [31:0] rf);
        if (s == 2'd1) return bus.mem_fwd;
        if (s == 2'd2) return bus.wb_fwd;
        return rf;
    endfunction

    function automatic bit is_mul_now();
        logic [5:0] f;
        f = bus.ex_instr[5:0];
        return MUL_EN && bus.ex_aluop == 2'd2
            && (f == 6'h18 || f == 6'h19);
    endfunction

    // m_cnt: -1 idle, 1..32 busy steps, 33 done cycle
    function automatic bit stall_exp();
        if (!reset || bus.flush) return 1'b0;
        if (m_cnt < 0) return is_mul_now();
        return m_cnt >= 1 && m_cnt <= 32;
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [31:0] a, bf, b, r;
        logic [5:0]  f;
        logic [4:0]  sh;
        logic signed [63:0] sa, sb;
        bit ok, st, bub;
        if (!reset) begin
            {e_alu, e_wdata, e_bt, e_wreg} = '0;
            {e_mw, e_mr, e_mt, e_rw, e_bk} = '0;
            m_hi = '0; m_lo = '0; m_cnt = -1;
        end else begin
            st  = stall_exp();
            bub = st || bus.flush;
            a   = fwd(bus.fwd_a, bus.ex_rd1);
            bf  = fwd(bus.fwd_b, bus.ex_rd2);
            b   = bus.ex_alusrc ? bus.ex_imm : bf;
            f   = bus.ex_instr[5:0];
            sh  = bus.ex_instr[10:6];
            ok  = 1'b1;
            r   = '0;
            case (bus.ex_aluop)
                2'd0: r = a + b;
                2'd1: r = a - b;
                2'd3: r = a | b;
                default:
                    case (f)
                        6'h20: r = a + b;
                        6'h22: r = a - b;
                        6'h24: r = a & b;
                        6'h25: r = a | b;
                        6'h27: r = ~(a | b);
                        6'h2A: r = {31'd0, $signed(a) < $signed(b)};
                        6'h00: r = b << sh;
                        6'h02: r = b >> sh;
                        6'h10: if (MUL_EN) r = m_hi; else ok = 0;
                        6'h12: if (MUL_EN) r = m_lo; else ok = 0;
                        default: ok = 1'b0;
                    endcase
            endcase
            e_alu   = r;
            e_wdata = bf;
            e_bt    = bus.ex_pc + (bus.ex_imm << 2);
            e_wreg  = bus.ex_regdst ? bus.ex_instr[15:11]
                                    : bus.ex_instr[20:16];
            e_mt = bus.ex_memtoreg;
            e_mw = bus.ex_memwrite && !bub;
            e_mr = bus.ex_memread && !bub;
            e_rw = bus.ex_regwrite && ok && !bub;
            e_bk = !bub && ((bus.ex_branch == 2'd1 && a == b)
                         || (bus.ex_branch == 2'd2 && a != b));
            if (bus.flush) begin
                m_cnt = -1;
            end else if (m_cnt < 0) begin
                if (is_mul_now()) begin
                    m_cnt = 1;
                    sa = $signed(a);
                    sb = $signed(b);
                    if (f == 6'h18) m_prod = sa * sb;
                    else m_prod = {32'd0, a} * {32'd0, b};
                end
            end else if (m_cnt <= 32) begin
                m_cnt++;
            end else begin
                {m_hi, m_lo} = m_prod;
                m_cnt = -1;
            end
        end
    end

    function automatic logic [105:0] dut_bundle();
        return {bus.mem_alu, bus.mem_wdata, bus.mem_btarget,
                bus.mem_wreg, bus.mem_memwrite, bus.mem_memread,
                bus.mem_memtoreg, bus.mem_regwrite, bus.mem_btaken};
    endfunction

    always @(negedge clk) begin
        logic [105:0] exp_b;
        if (chk_en) begin
            exp_b = {e_alu, e_wdata, e_bt, e_wreg,
                     e_mw, e_mr, e_mt, e_rw, e_bk};
            n_cmp++;
            if (dut_bundle() !== exp_b) begin
                n_bad++;
                $display("FAIL exmem @%0t: got %h expected %h",
                         $time, dut_bundle(), exp_b);
            end
            n_cmp++;
            if (bus.stall_out !== stall_exp()) begin
                n_bad++;
                $display("FAIL stall_out @%0t: got %b expected %b",
                         $time, bus.stall_out, stall_exp());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string nm, input logic [105:0] act,
                       input logic [105:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        bus.ex_alusrc = 0; bus.ex_regdst = 0;
        bus.ex_memwrite = 0; bus.ex_memread = 0;
        bus.ex_memtoreg = 0; bus.ex_regwrite = 0;
        bus.ex_aluop = 2'd0; bus.ex_branch = 2'd0;
        bus.ex_rd1 = '0; bus.ex_rd2 = '0; bus.ex_imm = '0;
        bus.ex_instr = '0; bus.ex_pc = '0;
        bus.fwd_a = 2'd0; bus.fwd_b = 2'd0;
        bus.mem_fwd = '0; bus.wb_fwd = '0; bus.flush = 0;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        clr();
        bus.ex_aluop = 2'd2; bus.ex_regdst = 1; bus.ex_regwrite = 1;
        bus.ex_rd1 = a; bus.ex_rd2 = b;
        bus.ex_instr = {6'd0, 5'd1, 5'd2, rd, 5'd0, f};
    endtask

`ifdef EX_MULT_EN
    task automatic run_mul(input string nm);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!bus.stall_out) break;
            n++;
            cyc();
        end
        chk(nm, n, 33);
        cyc();
    endtask
`endif

    initial begin
        reset = 1'b0;
        clr();
        repeat (3) cyc();
        chk("reset_outputs", dut_bundle(), '0);
        chk("reset_stall", bus.stall_out, 0);
        chk_en = 1'b1;
        reset = 1'b1;

        rtype(6'h20, 32'd7, 32'd5, 5'd3);
        cyc();
        chk("add_alu", bus.mem_alu, 12);
        chk("add_wreg", bus.mem_wreg, 3);
        chk("add_rw", bus.mem_regwrite, 1);

        clr();
        bus.ex_aluop = 2'd1; bus.ex_branch = 2'd1;
        bus.ex_rd1 = 9; bus.ex_rd2 = 9;
        bus.ex_imm = 4; bus.ex_pc = 32'h100;
        cyc();
        chk("beq_taken", bus.mem_btaken, 1);
        chk("beq_target", bus.mem_btarget, 32'h110);
        bus.ex_rd2 = 8;
        cyc();
        chk("beq_not_taken", bus.mem_btaken, 0);
        bus.ex_branch = 2'd2;
        cyc();
        chk("bne_taken", bus.mem_btaken, 1);
        bus.ex_branch = 2'd3;
        cyc();
        chk("br11_none", bus.mem_btaken, 0);
        bus.ex_branch = 2'd1; bus.ex_imm = 32'hFFFF_FFFF;
        bus.ex_rd2 = 9;
        cyc();
        chk("beq_back_target", bus.mem_btarget, 32'hFC);

        rtype(6'h22, 32'd0, 32'd0, 5'd4);
        bus.fwd_a = 2'd1; bus.mem_fwd = 32'h20;
        bus.fwd_b = 2'd2; bus.wb_fwd = 32'd3;
        cyc();
        chk("fwd_sub", bus.mem_alu, 32'h1D);
        chk("fwd_wdata", bus.mem_wdata, 3);
        bus.fwd_a = 2'd3; bus.fwd_b = 2'd3;
        bus.ex_rd1 = 50; bus.ex_rd2 = 8;
        cyc();
        chk("fwd11_rf", bus.mem_alu, 42);

        rtype(6'h24, 32'hF0F0, 32'hFF00, 5'd5);
        cyc();
        chk("and", bus.mem_alu, 32'hF000);
        rtype(6'h27, 32'h0F, 32'hF0, 5'd6);
        cyc();
        chk("nor", bus.mem_alu, 32'hFFFF_FF00);
        rtype(6'h00, 32'd0, 32'd1, 5'd7);
        bus.ex_instr[10:6] = 5'd31;
        cyc();
        chk("sll31", bus.mem_alu, 32'h8000_0000);
        rtype(6'h02, 32'd0, 32'h8000_0000, 5'd7);
        bus.ex_instr[10:6] = 5'd4;
        cyc();
        chk("srl4", bus.mem_alu, 32'h0800_0000);
        rtype(6'h20, 32'hFFFF_FFFF, 32'd2, 5'd8);
        cyc();
        chk("add_wrap", bus.mem_alu, 1);
        rtype(6'h3F, 32'd1, 32'd2, 5'd8);
        cyc();
        chk("unk_alu", bus.mem_alu, 0);
        chk("unk_rw", bus.mem_regwrite, 0);

        clr();
        bus.ex_aluop = 2'd3; bus.ex_alusrc = 1;
        bus.ex_regwrite = 1; bus.ex_rd1 = 32'h1200;
        bus.ex_imm = 32'h34; bus.ex_instr = {11'd0, 5'd9, 16'd0};
        cyc();
        chk("ori", bus.mem_alu, 32'h1234);
        chk("ori_wreg", bus.mem_wreg, 9);

        clr();
        bus.ex_alusrc = 1; bus.ex_memwrite = 1;
        bus.ex_rd1 = 32'h100; bus.ex_imm = 8; bus.ex_rd2 = 32'hAB;
        cyc();
        chk("sw_mw", bus.mem_memwrite, 1);
        bus.flush = 1;
        cyc();
        chk("flush_mw", bus.mem_memwrite, 0);
        chk("flush_alu", bus.mem_alu, 32'h108);
        chk("flush_wdata", bus.mem_wdata, 32'hAB);

`ifdef EX_MULT_EN
        rtype(6'h18, -32'sd3, 32'd7, 5'd9);
        run_mul("mult_stall_cycles");
        rtype(6'h12, 0, 0, 5'd10);
        cyc();
        chk("mflo", bus.mem_alu, 32'hFFFF_FFEB);
        chk("mflo_rw", bus.mem_regwrite, 1);
        rtype(6'h10, 0, 0, 5'd11);
        cyc();
        chk("mfhi", bus.mem_alu, 32'hFFFF_FFFF);

        rtype(6'h19, 32'hFFFF_FFFF, 32'd2, 5'd12);
        repeat (11) cyc();
        #1;
        chk("multu_busy", bus.stall_out, 1);
        bus.flush = 1;
        #1;
        chk("flush_drop", bus.stall_out, 0);
        cyc();
        rtype(6'h10, 0, 0, 5'd11);
        cyc();
        chk("hi_kept", bus.mem_alu, 32'hFFFF_FFFF);
        rtype(6'h12, 0, 0, 5'd11);
        cyc();
        chk("lo_kept", bus.mem_alu, 32'hFFFF_FFEB);
        rtype(6'h19, 32'hFFFF_FFFF, 32'd2, 5'd12);
        run_mul("multu_stall_cycles");
        rtype(6'h10, 0, 0, 5'd11);
        cyc();
        chk("multu_hi", bus.mem_alu, 1);
        rtype(6'h12, 0, 0, 5'd11);
        cyc();
        chk("multu_lo", bus.mem_alu, 32'hFFFF_FFFE);
`else
        rtype(6'h18, -32'sd3, 32'd7, 5'd9);
        #1;
        chk("mult_nostall", bus.stall_out, 0);
        cyc();
        chk("mult_alu", bus.mem_alu, 0);
        chk("mult_rw", bus.mem_regwrite, 0);
        rtype(6'h10, 0, 0, 5'd11);
        cyc();
        chk("mfhi_rw", bus.mem_regwrite, 0);
`endif

        rtype(6'h18, 32'd5, 32'd6, 5'd13);
        repeat (5) cyc();
        reset = 1'b0;
        #1;
        chk("rst_mid_out", dut_bundle(), '0);
        chk("rst_mid_stall", bus.stall_out, 0);
        cyc();
        cyc();
        rtype(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd14);
        reset = 1'b1;
        cyc();
        chk("slt", bus.mem_alu, 1);
        rtype(6'h10, 0, 0, 5'd11);
        cyc();
        chk("hi_after_rst", bus.mem_alu, 0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; consumes ID/EX register outputs and produces the registered EX/MEM bundle.
- Contains ALU control decode, operand forwarding muxes, ALU, branch resolution, and an iterative 32-step MULT/MULTU unit with HI/LO.
- Multi-cycle multiplies raise stall_out, which the hazard unit uses to freeze PC, IF/ID and ID/EX.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- MUL_STEPS, 32, shift-add iterations; must equal DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ex_alusrc, ex_regdst, ex_memwrite, ex_memread, ex_memtoreg, ex_regwrite  in  1 each  ID/EX control.
- ex_aluop, ex_branch  in  2 each  ID/EX control.
- ex_rd1, ex_rd2, ex_imm, ex_instr, ex_pc  in  32 each  ID/EX data; ex_pc is PC+4.
- fwd_a, fwd_b  in  2 each  forward select: 00 regfile, 01 mem_fwd, 10 wb_fwd.
- mem_fwd, wb_fwd  in  32 each  forwarded results.
- flush  in  1  squash the EX instruction.
- stall_out  out  1  multiplier busy.
- mem_alu, mem_wdata, mem_btarget  out  32 each  EX/MEM data.
- mem_wreg  out  5  destination register.
- mem_memwrite, mem_memread, mem_memtoreg, mem_regwrite, mem_btaken  out  1 each  EX/MEM control.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, FSM IDLE, HI=LO=0, step counter 0.
- Operands: A = fwd_a mux. B = ALUSrc ? ex_imm : fwd_b mux. mem_wdata = fwd_b mux output. fwd value 11 selects the regfile value.
- ALU control:
  - aluop 00 = ADD; 01 = SUB; 11 = OR.
  - aluop 10 decodes funct = instr[5:0]: 20 ADD, 22 SUB, 24 AND, 25 OR, 27 NOR, 2A SLT (signed), 00 SLL, 02 SRL (shamt = instr[10:6]), 10 MFHI, 12 MFLO, 18 MULT, 19 MULTU.
  - Any other funct produces 0 with regwrite forced to 0.
  - Arithmetic wraps modulo 2^32; there is no overflow trap.
- Destination: wreg = regdst ? instr[15:11] : instr[20:16].
- Branch:
  - btarget = ex_pc + (ex_imm << 2), truncated to 32 bits.
  - btaken = (branch==01 & A==B) | (branch==10 & A!=B).
  - branch==11 is treated as no branch.
- EX/MEM register: one-cycle latency; outputs update on every clk edge unless a bubble applies.
- Bubble: memwrite, memread, regwrite, btaken forced to 0; data fields still load.
- Multiplier FSM:
  - IDLE: MULT/MULTU present and flush=0 drives stall_out=1 combinationally. Latch |A|, |B| and the result sign (MULT) or raw operands (MULTU). Go to BUSY, counter=0. Bubble.
  - BUSY: one shift-add step per cycle; stall_out=1; bubble. Counter reaches MUL_STEPS-1, then go to DONE.
  - DONE: stall_out=0. {HI,LO} = 64-bit product, negated if the sign flag is set. Instruction retires to EX/MEM with regwrite=0. Go to IDLE.
  - Total occupancy: 34 cycles.
- MFHI/MFLO in the cycle after DONE read the updated HI/LO; the FSM guarantees no hazard.
- flush=1 in any state: FSM goes to IDLE, HI/LO are unchanged, stall_out=0, bubble in that cycle.
- flush has priority over MULT start.
- Reset mid-multiply: aborts the FSM; HI/LO=0.

Optional Feature:
- Macro EX_MULT_EN.
- Defined: multiplier FSM, HI/LO and MFHI/MFLO as specified above.
- Undefined: MULT/MULTU/MFHI/MFLO decode as unknown funct (result 0, regwrite 0). stall_out is tied 0. No HI/LO storage.

Decomposition:
- Shared package mips_pkg: ALU-op enum, funct constants, aluop encodings, fwd select encodings, mul FSM state enum.
- One sub-module, ex_mul_iter: FSM, counter, HI/LO, start/flush/busy/done interface.
- ALU control, forwarding muxes, ALU and the EX/MEM register stay in ex_stage.

Test Plan:
- ADD via aluop 10, funct 20, rd1=7, rd2=5, regdst=1, rd=3, regwrite=1 -> next edge mem_alu=12, mem_wreg=3, mem_regwrite=1.
- BEQ with rd1=rd2=9, imm=4, pc=0x100 -> mem_btaken=1, mem_btarget=0x110. Repeat with rd2=8 -> mem_btaken=0.
- Forwarding: fwd_a=01, mem_fwd=0x20, fwd_b=10, wb_fwd=3, SUB -> mem_alu=0x1D.
- MULT A=-3, B=7 -> stall_out high 33 cycles, bubbles. DONE then MFLO -> 0xFFFFFFEB; MFHI -> 0xFFFFFFFF.
- MULTU 0xFFFFFFFF × 2, flush pulsed at BUSY step 10 -> stall_out drops the same cycle; HI/LO keep prior values; restarted MULTU yields HI=1, LO=0xFFFFFFFE.
- reset low mid-BUSY -> all outputs 0 immediately; after release, SLT -1 < 1 -> mem_alu=1.
